led_speed_sched: RTL and testbench

Scheduler that drives the 24-bit `divider` word of the knight-rider LED pattern block, so the sweep speed follows a programmed sequence instead of a static value. Holds a small table of (divider, dwell) steps. It walks the table in order, ramping the divider linearly toward each target and holding it for the programmed dwell. Sits between the board control logic (buttons/registers) and the pattern block's `divider` input.

---
 rtl/led_speed_sched_if.sv | 34 +++
 rtl/led_speed_sched.sv | 166 ++++++++++++++++
 tb/tb_led_speed_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_speed_sched_if.sv
// Control/status bundle between the board control logic and the LED speed
// scheduler: table programming, sequence control and the divider output.
interface led_speed_sched_if #(
  parameter int DIV_W   = 24,
  parameter int STEPS   = 4,
  parameter int DWELL_W = 16
);
  localparam int AW = $clog2(STEPS);

  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [DIV_W-1:0]   cfg_div;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               loop;
  logic               start;
  logic               stop;
  logic [DIV_W-1:0]   divider;
  logic               busy;
  logic [AW-1:0]      step_idx;
  logic               done;
  logic               cfg_err;

  // Board control side: programs the table and starts/stops sequences.
  modport master (
    output cfg_we, cfg_addr, cfg_div, cfg_dwell, loop, start, stop,
    input  divider, busy, step_idx, done, cfg_err
  );

  // Scheduler side.
  modport slave (
    input  cfg_we, cfg_addr, cfg_div, cfg_dwell, loop, start, stop,
    output divider, busy, step_idx, done, cfg_err
  );
endinterface

// File: rtl/led_speed_sched.sv
// LED sweep-speed scheduler: walks a table of (divider, dwell) steps,
// ramping the knight-rider divider linearly toward each target and holding
// it for the programmed number of scheduler ticks.
module led_speed_sched #(
  parameter int               DIV_W       = 24,
  parameter int               STEPS       = 4,
  parameter int               DWELL_W     = 16,
  parameter int               TICK_DIV    = 50000,
  parameter int               RAMP_STEP   = 1000,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 24'd5000000
) (
  input logic              clk_src,
  input logic              reset_n,
  led_speed_sched_if.slave bus
);
  localparam int AW = $clog2(STEPS);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]      TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]      PRESC_ONE = PW'(1);
  localparam logic [DIV_W-1:0]   STEP_C    = DIV_W'(RAMP_STEP);
  localparam logic [AW-1:0]      LAST_IDX  = AW'(STEPS - 1);
  localparam logic [AW-1:0]      IDX_ONE   = AW'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam bit                 JUMP      = (RAMP_STEP == 0);

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, DWELL = 2'd2} state_t;

  state_t             state_r, state_nx_s;
  logic [PW-1:0]      presc_r, presc_nx_s;
  logic [DIV_W-1:0]   divider_r, divider_nx_s;
  logic [AW-1:0]      step_idx_r, step_nx_s;
  logic [DWELL_W-1:0] dwell_cnt_r, dwell_nx_s;
  logic               loop_r, loop_nx_s;
  logic               busy_r, done_r, done_nx_s, cfg_err_r, cfg_err_nx_s;
  logic [DIV_W-1:0]   div_tab_r   [STEPS];
  logic [DWELL_W-1:0] dwell_tab_r [STEPS];
  logic               tick_s, wr_ok_s;
  logic [DIV_W-1:0]   tgt_s, diff_s;

  // Unsigned distance between the current divider and a target.
  function automatic logic [DIV_W-1:0] abs_diff(input logic [DIV_W-1:0] a,
                                                input logic [DIV_W-1:0] b);
    if (a > b) return a - b;
    else       return b - a;
  endfunction

  assign tick_s  = (state_r != IDLE) && (presc_r == TICK_LAST);
  assign tgt_s   = div_tab_r[step_idx_r];
  assign diff_s  = abs_diff(divider_r, tgt_s);
  // A zero divider would stall the pattern block, so zero targets are refused.
  assign wr_ok_s = bus.cfg_we && (state_r == IDLE) && (bus.cfg_div != {DIV_W{1'b0}});
  assign cfg_err_nx_s = bus.cfg_we && !wr_ok_s;

  // Next-state and datapath decisions for the IDLE/RAMP/DWELL sequencer.
  always_comb begin
    state_nx_s   = state_r;
    divider_nx_s = divider_r;
    step_nx_s    = step_idx_r;
    dwell_nx_s   = dwell_cnt_r;
    loop_nx_s    = loop_r;
    done_nx_s    = 1'b0;
    if (tick_s || state_r == IDLE) presc_nx_s = {PW{1'b0}};
    else                           presc_nx_s = presc_r + PRESC_ONE;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          step_nx_s  = {AW{1'b0}};
          loop_nx_s  = bus.loop;
          state_nx_s = RAMP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RAMP: begin
        if (!tick_s) begin
          state_nx_s = RAMP;
        end else if (JUMP || diff_s <= STEP_C) begin
          divider_nx_s = tgt_s;
          dwell_nx_s   = dwell_tab_r[step_idx_r];
          state_nx_s   = DWELL;
        end else if (divider_r > tgt_s) begin
          divider_nx_s = divider_r - STEP_C;
        end else begin
          divider_nx_s = divider_r + STEP_C;
        end
      end
      DWELL: begin
        if (!tick_s) begin
          state_nx_s = DWELL;
        end else if (dwell_cnt_r != {DWELL_W{1'b0}}) begin
          dwell_nx_s = dwell_cnt_r - DWELL_ONE;
        end else if (step_idx_r != LAST_IDX) begin
          step_nx_s  = step_idx_r + IDX_ONE;
          state_nx_s = RAMP;
        end else if (loop_r) begin
          step_nx_s  = {AW{1'b0}};
          state_nx_s = RAMP;
        end else begin
          done_nx_s  = 1'b1;
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase

    // Abort wins over start and over any tick update: freeze divider/index.
    if (bus.stop) begin
      state_nx_s   = IDLE;
      divider_nx_s = divider_r;
      step_nx_s    = step_idx_r;
      dwell_nx_s   = dwell_cnt_r;
      loop_nx_s    = loop_r;
      presc_nx_s   = {PW{1'b0}};
      done_nx_s    = 1'b0;
    end else begin
      done_nx_s    = done_nx_s;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_src or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      presc_r     <= {PW{1'b0}};
      divider_r   <= DEFAULT_DIV;
      step_idx_r  <= {AW{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
      loop_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      presc_r     <= presc_nx_s;
      divider_r   <= divider_nx_s;
      step_idx_r  <= step_nx_s;
      dwell_cnt_r <= dwell_nx_s;
      loop_r      <= loop_nx_s;
      busy_r      <= (state_nx_s != IDLE);
      done_r      <= done_nx_s;
      cfg_err_r   <= cfg_err_nx_s;
    end
  end

  // Step table; a write in the same cycle as start lands before step 0 is read.
  always_ff @(posedge clk_src or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STEPS; i++) begin
        div_tab_r[i]   <= DEFAULT_DIV;
        dwell_tab_r[i] <= {DWELL_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      div_tab_r[bus.cfg_addr]   <= bus.cfg_div;
      dwell_tab_r[bus.cfg_addr] <= bus.cfg_dwell;
    end
  end

  assign bus.divider  = divider_r;
  assign bus.busy     = busy_r;
  assign bus.step_idx = step_idx_r;
  assign bus.done     = done_r;
  assign bus.cfg_err  = cfg_err_r;
endmodule

// File: tb/tb_led_speed_sched.sv
// Directed bench for led_speed_sched: a ramping build (RAMP_STEP=10) and a
// jump build (RAMP_STEP=0), both with TICK_DIV=4 and DEFAULT_DIV=100.
module tb_led_speed_sched;
  logic clk_src = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  led_speed_sched_if #(.DIV_W(24), .STEPS(4), .DWELL_W(16)) ifa ();
  led_speed_sched_if #(.DIV_W(24), .STEPS(4), .DWELL_W(16)) ifb ();

  led_speed_sched #(.DIV_W(24), .STEPS(4), .DWELL_W(16), .TICK_DIV(4),
                    .RAMP_STEP(10), .DEFAULT_DIV(24'd100))
    dut_a (.clk_src(clk_src), .reset_n(reset_n), .bus(ifa));

  led_speed_sched #(.DIV_W(24), .STEPS(4), .DWELL_W(16), .TICK_DIV(4),
                    .RAMP_STEP(0), .DEFAULT_DIV(24'd100))
    dut_b (.clk_src(clk_src), .reset_n(reset_n), .bus(ifb));

  always #5 clk_src = ~clk_src;

  task automatic cyc();
    @(posedge clk_src);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.cfg_we = 1'b0; ifa.cfg_addr = 2'd0; ifa.cfg_div = 24'd0; ifa.cfg_dwell = 16'd0;
    ifa.loop = 1'b0; ifa.start = 1'b0; ifa.stop = 1'b0;
    ifb.cfg_we = 1'b0; ifb.cfg_addr = 2'd0; ifb.cfg_div = 24'd0; ifb.cfg_dwell = 16'd0;
    ifb.loop = 1'b0; ifb.start = 1'b0; ifb.stop = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic write_a(input logic [1:0] a, input logic [23:0] d, input logic [15:0] w);
    ifa.cfg_we = 1'b1; ifa.cfg_addr = a; ifa.cfg_div = d; ifa.cfg_dwell = w;
    cyc();
    ifa.cfg_we = 1'b0;
  endtask

  task automatic write_b(input logic [1:0] a, input logic [23:0] d, input logic [15:0] w);
    ifb.cfg_we = 1'b1; ifb.cfg_addr = a; ifb.cfg_div = d; ifb.cfg_dwell = w;
    cyc();
    ifb.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) cyc();
    n_checks++; if (ifa.divider !== 24'd100) $display("FAIL rst_div got=%0d exp=100", ifa.divider); else n_pass++;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", ifa.busy); else n_pass++;
    n_checks++; if (ifa.step_idx !== 2'd0) $display("FAIL rst_idx got=%0d exp=0", ifa.step_idx); else n_pass++;
    n_checks++; if (ifa.done !== 1'b0) $display("FAIL rst_done got=%0b exp=0", ifa.done); else n_pass++;
    n_checks++; if (ifa.cfg_err !== 1'b0) $display("FAIL rst_cfg_err got=%0b exp=0", ifa.cfg_err); else n_pass++;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_ramp_down();
    int done_cnt = 0;
    write_a(2'd0, 24'd75, 16'd1);
    write_a(2'd1, 24'd75, 16'd0);
    write_a(2'd2, 24'd75, 16'd0);
    write_a(2'd3, 24'd75, 16'd0);
    n_checks++; if (ifa.cfg_err !== 1'b0) $display("FAIL rd_wr_err got=%0b exp=0", ifa.cfg_err); else n_pass++;
    ifa.loop = 1'b0; ifa.start = 1'b1;
    cyc();
    ifa.start = 1'b0;
    n_checks++; if (ifa.busy !== 1'b1) $display("FAIL rd_busy_rise got=%0b exp=1", ifa.busy); else n_pass++;
    for (int k = 1; k <= 50; k++) begin
      cyc();
      if (ifa.done === 1'b1) done_cnt++;
      case (k)
        3:  begin n_checks++; if (ifa.divider !== 24'd100) $display("FAIL rd_pre_tick got=%0d exp=100", ifa.divider); else n_pass++; end
        4:  begin n_checks++; if (ifa.divider !== 24'd90) $display("FAIL rd_tick1 got=%0d exp=90", ifa.divider); else n_pass++; end
        8:  begin n_checks++; if (ifa.divider !== 24'd80) $display("FAIL rd_tick2 got=%0d exp=80", ifa.divider); else n_pass++; end
        12: begin n_checks++; if (ifa.divider !== 24'd75) $display("FAIL rd_tick3 got=%0d exp=75", ifa.divider); else n_pass++; end
        19: begin n_checks++; if (ifa.step_idx !== 2'd0) $display("FAIL rd_dwell0 got=%0d exp=0", ifa.step_idx); else n_pass++; end
        20: begin n_checks++; if (ifa.step_idx !== 2'd1) $display("FAIL rd_step1 got=%0d exp=1", ifa.step_idx); else n_pass++; end
        36: begin n_checks++; if (ifa.step_idx !== 2'd3) $display("FAIL rd_step3 got=%0d exp=3", ifa.step_idx); else n_pass++; end
        43: begin n_checks++; if (ifa.busy !== 1'b1) $display("FAIL rd_busy_last got=%0b exp=1", ifa.busy); else n_pass++; end
        44: begin
          n_checks++; if (ifa.done !== 1'b1) $display("FAIL rd_done got=%0b exp=1", ifa.done); else n_pass++;
          n_checks++; if (ifa.busy !== 1'b0) $display("FAIL rd_busy_fall got=%0b exp=0", ifa.busy); else n_pass++;
        end
        default: ;
      endcase
    end
    n_checks++; if (done_cnt !== 1) $display("FAIL rd_done_count got=%0d exp=1", done_cnt); else n_pass++;
    n_checks++; if (ifa.divider !== 24'd75) $display("FAIL rd_final_div got=%0d exp=75", ifa.divider); else n_pass++;
  endtask

  task automatic test_ramp_up_loop();
    int done_cnt = 0;
    write_a(2'd0, 24'd130, 16'd0);
    write_a(2'd1, 24'd100, 16'd0);
    ifa.loop = 1'b1; ifa.start = 1'b1;
    cyc();
    ifa.start = 1'b0; ifa.loop = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      cyc();
      if (ifa.done === 1'b1) done_cnt++;
      case (k)
        4:  begin n_checks++; if (ifa.divider !== 24'd110) $display("FAIL ru_s0_t1 got=%0d exp=110", ifa.divider); else n_pass++; end
        8:  begin n_checks++; if (ifa.divider !== 24'd120) $display("FAIL ru_s0_t2 got=%0d exp=120", ifa.divider); else n_pass++; end
        12: begin n_checks++; if (ifa.divider !== 24'd130) $display("FAIL ru_s0_t3 got=%0d exp=130", ifa.divider); else n_pass++; end
        20: begin n_checks++; if (ifa.divider !== 24'd120) $display("FAIL ru_s1_t1 got=%0d exp=120", ifa.divider); else n_pass++; end
        24: begin n_checks++; if (ifa.divider !== 24'd110) $display("FAIL ru_s1_t2 got=%0d exp=110", ifa.divider); else n_pass++; end
        28: begin n_checks++; if (ifa.divider !== 24'd100) $display("FAIL ru_s1_t3 got=%0d exp=100", ifa.divider); else n_pass++; end
        47: begin n_checks++; if (ifa.step_idx !== 2'd3) $display("FAIL ru_idx3 got=%0d exp=3", ifa.step_idx); else n_pass++; end
        48: begin
          n_checks++; if (ifa.step_idx !== 2'd0) $display("FAIL ru_wrap got=%0d exp=0", ifa.step_idx); else n_pass++;
          n_checks++; if (ifa.busy !== 1'b1) $display("FAIL ru_busy_wrap got=%0b exp=1", ifa.busy); else n_pass++;
        end
        52: begin n_checks++; if (ifa.divider !== 24'd110) $display("FAIL ru_loop2 got=%0d exp=110", ifa.divider); else n_pass++; end
        default: ;
      endcase
    end
    n_checks++; if (done_cnt !== 0) $display("FAIL ru_no_done got=%0d exp=0", done_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    repeat (3) cyc();
    ifa.stop = 1'b1;
    cyc();
    ifa.stop = 1'b0;
    n_checks++; if (ifa.divider !== 24'd110) $display("FAIL ab_div got=%0d exp=110", ifa.divider); else n_pass++;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL ab_busy got=%0b exp=0", ifa.busy); else n_pass++;
    n_checks++; if (ifa.done !== 1'b0) $display("FAIL ab_done got=%0b exp=0", ifa.done); else n_pass++;
    repeat (8) cyc();
    n_checks++; if (ifa.divider !== 24'd110) $display("FAIL ab_hold got=%0d exp=110", ifa.divider); else n_pass++;
  endtask

  task automatic test_stop_start_same();
    ifa.start = 1'b1; ifa.stop = 1'b1;
    cyc();
    ifa.start = 1'b0; ifa.stop = 1'b0;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL ss_busy got=%0b exp=0", ifa.busy); else n_pass++;
    repeat (6) cyc();
    n_checks++; if (ifa.divider !== 24'd110) $display("FAIL ss_div got=%0d exp=110", ifa.divider); else n_pass++;
  endtask

  task automatic test_cfg_zero();
    write_a(2'd2, 24'd0, 16'd3);
    n_checks++; if (ifa.cfg_err !== 1'b1) $display("FAIL cz_err got=%0b exp=1", ifa.cfg_err); else n_pass++;
    cyc();
    n_checks++; if (ifa.cfg_err !== 1'b0) $display("FAIL cz_err_width got=%0b exp=0", ifa.cfg_err); else n_pass++;
  endtask

  task automatic test_cfg_busy();
    ifa.start = 1'b1;
    cyc();
    ifa.start = 1'b0;
    cyc();
    write_a(2'd0, 24'd200, 16'd5);
    n_checks++; if (ifa.cfg_err !== 1'b1) $display("FAIL cb_err got=%0b exp=1", ifa.cfg_err); else n_pass++;
    cyc();
    n_checks++; if (ifa.cfg_err !== 1'b0) $display("FAIL cb_err_width got=%0b exp=0", ifa.cfg_err); else n_pass++;
    cyc();
    n_checks++; if (ifa.divider !== 24'd120) $display("FAIL cb_run1 got=%0d exp=120", ifa.divider); else n_pass++;
    repeat (5) cyc();
    ifa.stop = 1'b1;
    cyc();
    ifa.stop = 1'b0;
    n_checks++; if (ifa.divider !== 24'd130) $display("FAIL cb_stop_div got=%0d exp=130", ifa.divider); else n_pass++;
    ifa.start = 1'b1;
    cyc();
    ifa.start = 1'b0;
    repeat (4) cyc();
    n_checks++; if (ifa.divider !== 24'd130) $display("FAIL cb_table_kept got=%0d exp=130", ifa.divider); else n_pass++;
    ifa.stop = 1'b1;
    cyc();
    ifa.stop = 1'b0;
  endtask

  task automatic test_cfg_with_start();
    apply_reset();
    ifa.cfg_we = 1'b1; ifa.cfg_addr = 2'd0; ifa.cfg_div = 24'd50; ifa.cfg_dwell = 16'd0;
    ifa.start = 1'b1;
    cyc();
    ifa.cfg_we = 1'b0; ifa.start = 1'b0;
    n_checks++; if (ifa.cfg_err !== 1'b0) $display("FAIL cs_err got=%0b exp=0", ifa.cfg_err); else n_pass++;
    repeat (4) cyc();
    n_checks++; if (ifa.divider !== 24'd90) $display("FAIL cs_t1 got=%0d exp=90", ifa.divider); else n_pass++;
    repeat (4) cyc();
    n_checks++; if (ifa.divider !== 24'd80) $display("FAIL cs_t2 got=%0d exp=80", ifa.divider); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (ifa.divider !== 24'd100) $display("FAIL mr_div got=%0d exp=100", ifa.divider); else n_pass++;
    n_checks++; if (ifa.busy !== 1'b0) $display("FAIL mr_busy got=%0b exp=0", ifa.busy); else n_pass++;
    cyc();
    reset_n = 1'b1;
    cyc();
    ifa.start = 1'b1;
    cyc();
    ifa.start = 1'b0;
    repeat (4) cyc();
    n_checks++; if (ifa.divider !== 24'd100) $display("FAIL mr_table_clr got=%0d exp=100", ifa.divider); else n_pass++;
    ifa.stop = 1'b1;
    cyc();
    ifa.stop = 1'b0;
  endtask

  task automatic test_ramp_jump();
    write_b(2'd0, 24'd300, 16'd0);
    write_b(2'd1, 24'd20, 16'd1);
    ifb.start = 1'b1;
    cyc();
    ifb.start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      cyc();
      case (k)
        4:  begin n_checks++; if (ifb.divider !== 24'd300) $display("FAIL rj_s0 got=%0d exp=300", ifb.divider); else n_pass++; end
        12: begin n_checks++; if (ifb.divider !== 24'd20) $display("FAIL rj_s1 got=%0d exp=20", ifb.divider); else n_pass++; end
        24: begin
          n_checks++; if (ifb.divider !== 24'd100) $display("FAIL rj_s2 got=%0d exp=100", ifb.divider); else n_pass++;
          n_checks++; if (ifb.step_idx !== 2'd2) $display("FAIL rj_idx2 got=%0d exp=2", ifb.step_idx); else n_pass++;
        end
        36: begin n_checks++; if (ifb.done !== 1'b1) $display("FAIL rj_done got=%0b exp=1", ifb.done); else n_pass++; end
        default: ;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_ramp_down();
    apply_reset();
    test_ramp_up_loop();
    test_abort();
    test_stop_start_same();
    test_cfg_zero();
    test_cfg_busy();
    test_cfg_with_start();
    test_ramp_jump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
